// File: rtl/s2qed_pkg.sv
// Shared definitions for the S2QED UART pair monitor: receiver state encoding and framing constants.
// Latency: n/a (package only).
// Backpressure: none.
package s2qed_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_IDLE
   } rx_state_e;

   localparam int DATA_BITS        = 8;
   localparam int CLKS_PER_BIT_DEF = 16;

   // Even parity: the parity bit that makes the total count of ones even.
   function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/s2qed_uart_rx.sv
// Single-channel UART receiver, 8N1 (8E1 when S2QED_PARITY_EN is defined), sampled at mid-bit.
// Latency: valid_o/frame_err_o pulse 1 cycle after the mid-stop-bit sample.
// Backpressure: none; the line is never stalled, each result is a one-cycle pulse.
module s2qed_uart_rx
   import s2qed_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 rxd_i,
   output logic                 valid_o,
   output logic [DATA_BITS-1:0] data_o,
   output logic                 frame_err_o
);

   localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]        LAST_BIT  = 4'(DATA_BITS - 1);

   rx_state_e            state_q, state_d;
   logic [BAUD_W-1:0]    baud_q, baud_d;
   logic [3:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 valid_pend_q, valid_pend_d;
   logic                 err_pend_q, err_pend_d;
   logic                 valid_q;
   logic                 err_q;
   logic [DATA_BITS-1:0] data_q;
`ifdef S2QED_PARITY_EN
   logic                 par_ok_q, par_ok_d;
`endif

   always_comb begin
      state_d      = state_q;
      baud_d       = baud_q + BAUD_W'(1);
      bit_d        = bit_q;
      shift_d      = shift_q;
      valid_pend_d = 1'b0;
      err_pend_d   = 1'b0;
`ifdef S2QED_PARITY_EN
      par_ok_d     = par_ok_q;
`endif
      unique case (state_q)
         IDLE: begin
            baud_d = '0;
            if (!rxd_i) begin
               state_d = START;
               bit_d   = '0;
            end
         end
         START: begin
            // Half a bit in: a line that has gone high again was only a glitch.
            if (baud_q == HALF_LAST) begin
               baud_d  = '0;
               state_d = rxd_i ? IDLE : DATA;
            end
         end
         DATA: begin
            if (baud_q == FULL_LAST) begin
               baud_d  = '0;
               shift_d = {rxd_i, shift_q[DATA_BITS-1:1]};
               bit_d   = bit_q + 4'd1;
               if (bit_q == LAST_BIT) begin
`ifdef S2QED_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef S2QED_PARITY_EN
         PARITY: begin
            if (baud_q == FULL_LAST) begin
               baud_d   = '0;
               par_ok_d = (rxd_i == even_parity(shift_q));
               state_d  = STOP;
            end
         end
`endif
         STOP: begin
            if (baud_q == FULL_LAST) begin
               baud_d = '0;
               if (rxd_i) begin
                  state_d = IDLE;
`ifdef S2QED_PARITY_EN
                  valid_pend_d = par_ok_q;
                  err_pend_d   = !par_ok_q;
`else
                  valid_pend_d = 1'b1;
`endif
               end else begin
                  err_pend_d = 1'b1;
                  state_d    = WAIT_IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            // A break holds the line low; resynchronise only once it idles high.
            baud_d = '0;
            if (rxd_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            baud_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         baud_q       <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         valid_pend_q <= 1'b0;
         err_pend_q   <= 1'b0;
         valid_q      <= 1'b0;
         err_q        <= 1'b0;
         data_q       <= '0;
`ifdef S2QED_PARITY_EN
         par_ok_q     <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         baud_q       <= baud_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         valid_pend_q <= valid_pend_d;
         err_pend_q   <= err_pend_d;
         valid_q      <= valid_pend_q;
         err_q        <= err_pend_q;
         if (valid_pend_q) begin
            data_q <= shift_q;
         end
`ifdef S2QED_PARITY_EN
         par_ok_q     <= par_ok_d;
`endif
      end
   end

   assign valid_o     = valid_q;
   assign data_o      = data_q;
   assign frame_err_o = err_q;

endmodule

// File: rtl/s2qed_uart_pair_monitor.sv
// Terminates both S2QED TXD lines, decodes each stream and flags any cycle-level divergence (S2QED_PARITY_EN adds even parity).
// Latency: start edge to rx_valid = 9.5*CLKS_PER_BIT+1 cycles; mismatch_pulse/match_count follow 1 cycle later.
// Backpressure: none; comparator runs every cycle, qed_mismatch is sticky until RST.
module s2qed_uart_pair_monitor
   import s2qed_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int CNT_W        = 16
) (
   input  logic                 CLK_SRC,
   input  logic                 RST,
   input  logic                 TXD_0,
   input  logic                 TXD_1,
   output logic                 rx_valid_0,
   output logic [DATA_BITS-1:0] rx_data_0,
   output logic                 frame_err_0,
   output logic                 rx_valid_1,
   output logic [DATA_BITS-1:0] rx_data_1,
   output logic                 frame_err_1,
   output logic                 mismatch_pulse,
   output logic                 qed_mismatch,
   output logic [CNT_W-1:0]     match_count
);

   logic             diverge;
   logic             matched;
   logic             mismatch_pulse_q, mismatch_pulse_d;
   logic             qed_mismatch_q, qed_mismatch_d;
   logic [CNT_W-1:0] match_count_q, match_count_d;

   s2qed_uart_rx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx_0 (
      .clk_i      (CLK_SRC),
      .rst_i      (RST),
      .rxd_i      (TXD_0),
      .valid_o    (rx_valid_0),
      .data_o     (rx_data_0),
      .frame_err_o(frame_err_0)
   );

   s2qed_uart_rx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx_1 (
      .clk_i      (CLK_SRC),
      .rst_i      (RST),
      .rxd_i      (TXD_1),
      .valid_o    (rx_valid_1),
      .data_o     (rx_data_1),
      .frame_err_o(frame_err_1)
   );

   // Identical instances must produce identical pulses in the same cycle; any skew counts.
   always_comb begin
      diverge = (rx_valid_0 != rx_valid_1)
              || (frame_err_0 != frame_err_1)
              || (rx_valid_0 && rx_valid_1 && (rx_data_0 != rx_data_1));
      matched = rx_valid_0 && rx_valid_1 && (rx_data_0 == rx_data_1);

      mismatch_pulse_d = diverge;
      qed_mismatch_d   = qed_mismatch_q || diverge;
      match_count_d    = match_count_q;
      if (matched && (match_count_q != {CNT_W{1'b1}})) begin
         match_count_d = match_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK_SRC or posedge RST) begin
      if (RST) begin
         mismatch_pulse_q <= 1'b0;
         qed_mismatch_q   <= 1'b0;
         match_count_q    <= '0;
      end else begin
         mismatch_pulse_q <= mismatch_pulse_d;
         qed_mismatch_q   <= qed_mismatch_d;
         match_count_q    <= match_count_d;
      end
   end

   assign mismatch_pulse = mismatch_pulse_q;
   assign qed_mismatch   = qed_mismatch_q;
   assign match_count    = match_count_q;

endmodule

// File: tb/tb_s2qed_uart_pair_monitor.sv
// Bench for s2qed_uart_pair_monitor: waveform-level stimulus per scenario, expectations from a frame-event model.
module tb_s2qed_uart_pair_monitor;

   localparam int CPB = 4;
`ifdef S2QED_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif
   // Step index (sampled before edge) at which a frame starting at step s shows its result.
   localparam int LAT = (FB - 1) * CPB + CPB / 2 + 2;
   localparam int N   = 1024;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       txd_0 = 1'b1;
   logic       txd_1 = 1'b1;
   logic       rx_valid_0, rx_valid_1, frame_err_0, frame_err_1;
   logic [7:0] rx_data_0, rx_data_1;
   logic       mismatch_pulse, qed_mismatch;
   logic [15:0] match_count;
   logic       s_valid_0, s_valid_1, s_err_0, s_err_1, s_mp, s_qed;
   logic [7:0] s_data_0, s_data_1;
   logic [3:0] s_count;

   int n_assert = 0;
   int n_fail   = 0;

   bit         w0 [N];
   bit         w1 [N];
   bit         ev0 [N];
   bit         ev1 [N];
   bit         ee0 [N];
   bit         ee1 [N];
   logic [7:0] ed0 [N];
   logic [7:0] ed1 [N];
   // {v0,e0,d0,v1,e1,d1,mp,qed,count16,count4}
   logic [41:0] obs_pk [N];
   logic [41:0] exp_pk [N];

   always #5 clk = ~clk;

   s2qed_uart_pair_monitor #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
      .CLK_SRC(clk), .RST(rst), .TXD_0(txd_0), .TXD_1(txd_1),
      .rx_valid_0(rx_valid_0), .rx_data_0(rx_data_0), .frame_err_0(frame_err_0),
      .rx_valid_1(rx_valid_1), .rx_data_1(rx_data_1), .frame_err_1(frame_err_1),
      .mismatch_pulse(mismatch_pulse), .qed_mismatch(qed_mismatch), .match_count(match_count)
   );

   // Narrow counter copy so saturation is reachable in a short run.
   s2qed_uart_pair_monitor #(.CLKS_PER_BIT(CPB), .CNT_W(4)) dut_sat (
      .CLK_SRC(clk), .RST(rst), .TXD_0(txd_0), .TXD_1(txd_1),
      .rx_valid_0(s_valid_0), .rx_data_0(s_data_0), .frame_err_0(s_err_0),
      .rx_valid_1(s_valid_1), .rx_data_1(s_data_1), .frame_err_1(s_err_1),
      .mismatch_pulse(s_mp), .qed_mismatch(s_qed), .match_count(s_count)
   );

   initial begin
      #2ms;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic clear_wave();
      for (int i = 0; i < N; i++) begin
         w0[i] = 1'b1; w1[i] = 1'b1;
         ev0[i] = 1'b0; ev1[i] = 1'b0; ee0[i] = 1'b0; ee1[i] = 1'b0;
         ed0[i] = 8'h00; ed1[i] = 8'h00;
      end
   endtask

   task automatic set_bit(input int ch, input int idx, input bit v);
      if (ch == 0) w0[idx] = v; else w1[idx] = v;
   endtask

   task automatic put_frame(input int ch, input int s, input logic [7:0] b,
                            input bit bad_par, input bit expect_evt);
      logic [FB-1:0] bits;
      bits = '1;
      bits[0] = 1'b0;
      bits[8:1] = b;
`ifdef S2QED_PARITY_EN
      bits[9] = (^b) ^ bad_par;
`endif
      for (int i = 0; i < FB; i++)
         for (int k = 0; k < CPB; k++)
            set_bit(ch, s + i * CPB + k, bits[i]);
      if (expect_evt) begin
         if (bad_par) begin
            if (ch == 0) ee0[s + LAT] = 1'b1; else ee1[s + LAT] = 1'b1;
         end else if (ch == 0) begin
            ev0[s + LAT] = 1'b1; ed0[s + LAT] = b;
         end else begin
            ev1[s + LAT] = 1'b1; ed1[s + LAT] = b;
         end
      end
   endtask

   task automatic put_low(input int ch, input int s, input int len, input bit expect_err);
      for (int i = 0; i < len; i++) set_bit(ch, s + i, 1'b0);
      if (expect_err) begin
         if (ch == 0) ee0[s + LAT] = 1'b1; else ee1[s + LAT] = 1'b1;
      end
   endtask

   // Reference: receivers report the scheduled frame events; comparator acts on them one cycle later.
   task automatic build_exp(input int len);
      logic [7:0]  h0, h1;
      logic        mp, qed, div, mt;
      logic [15:0] c16;
      logic [3:0]  c4;
      h0 = 8'h00; h1 = 8'h00; mp = 1'b0; qed = 1'b0; c16 = 16'h0; c4 = 4'h0;
      for (int c = 0; c < len; c++) begin
         if (ev0[c]) h0 = ed0[c];
         if (ev1[c]) h1 = ed1[c];
         exp_pk[c] = {ev0[c], ee0[c], h0, ev1[c], ee1[c], h1, mp, qed, c16, c4};
         div = (ev0[c] != ev1[c]) || (ee0[c] != ee1[c]) || (ev0[c] && ev1[c] && ed0[c] != ed1[c]);
         mt  = ev0[c] && ev1[c] && (ed0[c] == ed1[c]);
         mp  = div;
         qed = qed | div;
         if (mt && c16 != 16'hFFFF) c16 = c16 + 16'd1;
         if (mt && c4 != 4'hF) c4 = c4 + 4'd1;
      end
   endtask

   task automatic run(input int len);
      build_exp(len);
      for (int c = 0; c < len; c++) begin
         @(negedge clk);
         obs_pk[c] = {rx_valid_0, frame_err_0, rx_data_0, rx_valid_1, frame_err_1, rx_data_1,
                      mismatch_pulse, qed_mismatch, match_count, s_count};
         txd_0 = w0[c];
         txd_1 = w1[c];
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; txd_0 = 1'b1; txd_1 = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic int count_bit(input int len, input int pos);
      int n = 0;
      for (int c = 0; c < len; c++) if (obs_pk[c][pos]) n++;
      return n;
   endfunction

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; txd_0 = 1'b1; txd_1 = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_assert++;
      if ({rx_valid_0, frame_err_0, rx_data_0, rx_valid_1, frame_err_1, rx_data_1} !== 20'h0) begin
         n_fail++; $display("FAIL reset_rx got=%h exp=0",
            {rx_valid_0, frame_err_0, rx_data_0, rx_valid_1, frame_err_1, rx_data_1});
      end
      n_assert++;
      if ({mismatch_pulse, qed_mismatch, match_count} !== 18'h0) begin
         n_fail++; $display("FAIL reset_cmp got=%h exp=0", {mismatch_pulse, qed_mismatch, match_count});
      end
      rst = 1'b0;
      @(negedge clk);
      n_assert++;
      if ({rx_valid_0, rx_valid_1, qed_mismatch, match_count} !== 19'h0) begin
         n_fail++; $display("FAIL reset_release got=%h exp=0", {rx_valid_0, rx_valid_1, qed_mismatch, match_count});
      end
   endtask

   task automatic test_lockstep();
      int s = 2, len;
      do_reset(); clear_wave();
      put_frame(0, s, 8'hA5, 1'b0, 1'b1);
      put_frame(1, s, 8'hA5, 1'b0, 1'b1);
      len = s + LAT + 4;
      run(len);
      for (int c = 0; c < len; c++) begin
         n_assert++;
         if (obs_pk[c] !== exp_pk[c]) begin
            n_fail++; $display("FAIL lockstep cyc=%0d got=%h exp=%h", c, obs_pk[c], exp_pk[c]);
         end
      end
      n_assert++;
      if ({obs_pk[s + LAT - 1][41], obs_pk[s + LAT][41], obs_pk[s + LAT][31]} !== 3'b011) begin
         n_fail++; $display("FAIL lockstep_latency got=%b exp=011",
            {obs_pk[s + LAT - 1][41], obs_pk[s + LAT][41], obs_pk[s + LAT][31]});
      end
      n_assert++;
      if ({obs_pk[len - 1][39:32], obs_pk[len - 1][20], obs_pk[len - 1][19:4]} !== {8'hA5, 1'b0, 16'd1}) begin
         n_fail++; $display("FAIL lockstep_final got=%h exp=%h",
            {obs_pk[len - 1][39:32], obs_pk[len - 1][20], obs_pk[len - 1][19:4]}, {8'hA5, 1'b0, 16'd1});
      end
   endtask

   task automatic test_data_mismatch();
      int s = 2, t, len;
      do_reset(); clear_wave();
      put_frame(0, s, 8'h3C, 1'b0, 1'b1);
      put_frame(1, s, 8'h3D, 1'b0, 1'b1);
      t = s + FB * CPB;
      for (int i = 0; i < 2; i++) begin
         put_frame(0, t, 8'h69 + 8'(i), 1'b0, 1'b1);
         put_frame(1, t, 8'h69 + 8'(i), 1'b0, 1'b1);
         t += FB * CPB;
      end
      len = t - FB * CPB + LAT + 4;
      run(len);
      for (int c = 0; c < len; c++) begin
         n_assert++;
         if (obs_pk[c] !== exp_pk[c]) begin
            n_fail++; $display("FAIL data_mismatch cyc=%0d got=%h exp=%h", c, obs_pk[c], exp_pk[c]);
         end
      end
      n_assert++;
      if (count_bit(len, 21) != 1) begin
         n_fail++; $display("FAIL data_mismatch_pulses got=%0d exp=1", count_bit(len, 21));
      end
      n_assert++;
      if ({obs_pk[len - 1][20], obs_pk[len - 1][19:4]} !== {1'b1, 16'd2}) begin
         n_fail++; $display("FAIL data_mismatch_sticky got=%h exp=%h",
            {obs_pk[len - 1][20], obs_pk[len - 1][19:4]}, {1'b1, 16'd2});
      end
   endtask

   task automatic test_skew();
      int s = 2, len;
      do_reset(); clear_wave();
      put_frame(0, s, 8'h55, 1'b0, 1'b1);
      put_frame(1, s + 1, 8'h55, 1'b0, 1'b1);
      len = s + LAT + 6;
      run(len);
      for (int c = 0; c < len; c++) begin
         n_assert++;
         if (obs_pk[c] !== exp_pk[c]) begin
            n_fail++; $display("FAIL skew cyc=%0d got=%h exp=%h", c, obs_pk[c], exp_pk[c]);
         end
      end
      n_assert++;
      if ({obs_pk[s + LAT + 1][21], obs_pk[s + LAT + 2][21], obs_pk[len - 1][20], obs_pk[len - 1][19:4]}
          !== {3'b111, 16'd0}) begin
         n_fail++; $display("FAIL skew_cmp got=%h exp=%h",
            {obs_pk[s + LAT + 1][21], obs_pk[s + LAT + 2][21], obs_pk[len - 1][20], obs_pk[len - 1][19:4]},
            {3'b111, 16'd0});
      end
   endtask

   task automatic test_glitch_break();
      int s = 2, brk = FB * CPB + 8, t, len;
      do_reset(); clear_wave();
      put_low(0, s, 1, 1'b0);
      put_low(1, s, brk, 1'b1);
      t = s + brk + 4;
      put_frame(0, t, 8'h5A, 1'b0, 1'b1);
      put_frame(1, t, 8'h5A, 1'b0, 1'b1);
      len = t + LAT + 4;
      run(len);
      for (int c = 0; c < len; c++) begin
         n_assert++;
         if (obs_pk[c] !== exp_pk[c]) begin
            n_fail++; $display("FAIL glitch_break cyc=%0d got=%h exp=%h", c, obs_pk[c], exp_pk[c]);
         end
      end
      n_assert++;
      if ({count_bit(len, 40), count_bit(len, 30), count_bit(len, 41)} != {32'd0, 32'd1, 32'd1}) begin
         n_fail++; $display("FAIL glitch_break_counts got err0=%0d err1=%0d v0=%0d exp 0 1 1",
            count_bit(len, 40), count_bit(len, 30), count_bit(len, 41));
      end
      n_assert++;
      if ({obs_pk[len - 1][20], obs_pk[len - 1][19:4]} !== {1'b1, 16'd1}) begin
         n_fail++; $display("FAIL glitch_break_final got=%h exp=%h",
            {obs_pk[len - 1][20], obs_pk[len - 1][19:4]}, {1'b1, 16'd1});
      end
   endtask

   task automatic test_reset_mid_frame();
      int s = 2, len;
      do_reset(); clear_wave();
      put_frame(0, s, 8'hFF, 1'b0, 1'b0);
      put_frame(1, s, 8'hFF, 1'b0, 1'b0);
      run(20);
      do_reset();
      for (int i = 0; i < 6 * CPB; i++) begin
         @(negedge clk);
         n_assert++;
         if ({rx_valid_0, rx_valid_1, frame_err_0, frame_err_1, mismatch_pulse} !== 5'b0) begin
            n_fail++; $display("FAIL abort_quiet got=%b exp=00000",
               {rx_valid_0, rx_valid_1, frame_err_0, frame_err_1, mismatch_pulse});
         end
      end
      clear_wave();
      put_frame(0, s, 8'h00, 1'b0, 1'b1);
      put_frame(1, s, 8'h00, 1'b0, 1'b1);
      len = s + LAT + 4;
      run(len);
      for (int c = 0; c < len; c++) begin
         n_assert++;
         if (obs_pk[c] !== exp_pk[c]) begin
            n_fail++; $display("FAIL reset_mid_frame cyc=%0d got=%h exp=%h", c, obs_pk[c], exp_pk[c]);
         end
      end
      n_assert++;
      if ({obs_pk[s + LAT][41], obs_pk[s + LAT][39:32], obs_pk[len - 1][19:4]} !== {1'b1, 8'h00, 16'd1}) begin
         n_fail++; $display("FAIL reset_mid_frame_final got=%h exp=%h",
            {obs_pk[s + LAT][41], obs_pk[s + LAT][39:32], obs_pk[len - 1][19:4]}, {1'b1, 8'h00, 16'd1});
      end
   endtask

   task automatic test_random();
      int t = 2, len;
      logic [7:0] b0, b1;
      bit bad;
      do_reset(); clear_wave();
      for (int i = 0; i < 12; i++) begin
         b0 = 8'($urandom_range(0, 255));
         b1 = ($urandom_range(0, 3) == 0) ? (b0 ^ (8'd1 << $urandom_range(0, 7))) : b0;
`ifdef S2QED_PARITY_EN
         bad = ($urandom_range(0, 4) == 0);
`else
         bad = 1'b0;
`endif
         put_frame(0, t, b0, bad, 1'b1);
         put_frame(1, t, b1, bad, 1'b1);
         t += FB * CPB + int'($urandom_range(0, 3));
      end
      len = t + LAT;
      run(len);
      for (int c = 0; c < len; c++) begin
         n_assert++;
         if (obs_pk[c] !== exp_pk[c]) begin
            n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", c, obs_pk[c], exp_pk[c]);
         end
      end
   endtask

   task automatic test_saturate();
      int t = 2, len;
      logic [7:0] b;
      do_reset(); clear_wave();
      for (int i = 0; i < 20; i++) begin
         b = 8'($urandom_range(0, 255));
         put_frame(0, t, b, 1'b0, 1'b1);
         put_frame(1, t, b, 1'b0, 1'b1);
         t += FB * CPB;
      end
      len = t - FB * CPB + LAT + 3;
      run(len);
      for (int c = 0; c < len; c++) begin
         n_assert++;
         if (obs_pk[c] !== exp_pk[c]) begin
            n_fail++; $display("FAIL saturate cyc=%0d got=%h exp=%h", c, obs_pk[c], exp_pk[c]);
         end
      end
      n_assert++;
      if ({obs_pk[len - 1][19:4], obs_pk[len - 1][3:0]} !== {16'd20, 4'hF}) begin
         n_fail++; $display("FAIL saturate_final got=%h exp=%h",
            {obs_pk[len - 1][19:4], obs_pk[len - 1][3:0]}, {16'd20, 4'hF});
      end
   endtask

`ifdef S2QED_PARITY_EN
   task automatic test_parity();
      int s = 2, len;
      do_reset(); clear_wave();
      put_frame(0, s, 8'h01, 1'b1, 1'b1);
      put_frame(1, s, 8'h01, 1'b1, 1'b1);
      put_frame(0, s + FB * CPB, 8'h01, 1'b0, 1'b1);
      put_frame(1, s + FB * CPB, 8'h01, 1'b0, 1'b1);
      len = s + FB * CPB + LAT + 4;
      run(len);
      for (int c = 0; c < len; c++) begin
         n_assert++;
         if (obs_pk[c] !== exp_pk[c]) begin
            n_fail++; $display("FAIL parity cyc=%0d got=%h exp=%h", c, obs_pk[c], exp_pk[c]);
         end
      end
      n_assert++;
      if ({obs_pk[s + LAT][40], obs_pk[s + LAT][30], obs_pk[s + LAT][41], count_bit(len, 21) == 0}
          !== 4'b1101) begin
         n_fail++; $display("FAIL parity_err got=%b exp=1101",
            {obs_pk[s + LAT][40], obs_pk[s + LAT][30], obs_pk[s + LAT][41], count_bit(len, 21) == 0});
      end
   endtask
`endif

   initial begin
      test_reset();
      test_lockstep();
      test_data_mismatch();
      test_skew();
      test_glitch_break();
      test_reset_mid_frame();
      test_random();
      test_saturate();
`ifdef S2QED_PARITY_EN
      test_parity();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
